cdr_loop_filter: RTL and testbench
==================================

# cdr_loop_filter

Digital loop filter of the RX clock-and-data-recovery loop; it consumes the bang-bang phase detector's per-UI `decision` code. Votes are accumulated over a decimation window, reduced to a sign, and passed through a proportional + integral path. The result is a wrapping phase-interpolator code. It also flags lock when window votes stay balanced for several consecutive windows.

## Interface
Parameters:
- `DEC`, 8: decisions per decimation window (≥2).
- `KP`, 4: proportional gain, in PI steps per window sign.
- `KI`, 1: integral gain, in integrator LSBs per window sign.
- `INT_W`, 12: integrator width (signed).
- `FRAC`, 4: integrator fractional bits; integral step = `freq_int >>> FRAC`.
- `PI_W`, 7: phase-interpolator code width.
- `LOCK_TH`, 2: maximum |window sum| that counts as a balanced window.
- `LOCK_N`, 4: consecutive balanced windows required to assert `lock`.

Ports:
- `clk` input 1: single clock.
- `rst` input 1: reset, synchronous, active-high.
- `en` input 1: qualifies `decision` this cycle.
- `decision` input 2: phase-detector code.
- `pi_code` output PI_W: phase-interpolator code, registered.
- `pi_valid` output 1: one-cycle pulse on each window update.
- `freq_int` output INT_W: signed integrator state.
- `lock` output 1: lock indicator.

## Operation
- Vote decode: 2'b11 (early) → +1; 2'b01 (late) → −1; 2'b00 and 2'b10 → 0.
- Cycles with `en`=0 are ignored entirely: the window count, the sum and all outputs hold.
- The window counter counts en-qualified cycles from 0 to DEC−1.
- The signed window sum must hold ±DEC without overflow.
- On the en-qualified cycle where the counter = DEC−1, compute the window total `tot` = sum + current vote and s = sign(`tot`) ∈ {−1, 0, +1}. Then, on the same edge:
  - `freq_int` ← saturate(`freq_int` + KI·s) to [−2^(INT_W−1), 2^(INT_W−1)−1].
  - step = KP·s + (new `freq_int` >>> FRAC), using an arithmetic shift (floor).
  - `pi_code` ← (`pi_code` + step) mod 2^PI_W. Wrap-around in both directions is intended; there is no saturation.
  - `pi_valid` ← 1. It pulses even when s = 0 or step = 0.
  - Window counter and sum clear to 0.
- Lock logic, on each window update:
  - If |`tot`| ≤ LOCK_TH, the lock counter increments, saturating at LOCK_N. Otherwise it clears to 0.
  - `lock` = (lock counter == LOCK_N), registered. It drops on the same edge as the failing window's update.
- All arithmetic is signed and sized so that no intermediate term overflows before the modulo/saturation step.
- `rst` has priority over `en`. It clears the window counter, sum, integrator, lock counter and all outputs, including mid-window; any partial window is discarded.

## Timing
- Reset values: `pi_code`=0, `pi_valid`=0, `freq_int`=0, `lock`=0.
- Update latency: `pi_code`, `freq_int`, `lock` and `pi_valid` are updated at the edge that samples the DEC-th qualified decision. They are visible the cycle after that edge.
- `pi_valid` is high for exactly one cycle per completed window and low otherwise.
- Maximum update rate: one update every DEC cycles with `en` held high.
- No backpressure exists; the downstream interpolator must accept every update.

## Test plan
All scenarios use default parameters.
- Reset: hold `rst` with `en`=1 and `decision`=11 for 20 cycles → all outputs stay 0 and `pi_valid` never pulses.
- One early window: 8 qualified 11s from reset → after the 8th edge, `pi_code`=4, `freq_int`=1, and `pi_valid` is high for 1 cycle.
- Late run: 16 windows of all-01 from reset → each step = −5, giving `freq_int`=−16 and `pi_code`=48 (wrapped below 0).
- Early run and upward wrap: 31 windows of all-11 → `freq_int`=31 and `pi_code`=12. Steps are 4 for windows 1–15 and 5 for windows 16–31.
- Balanced input and lock: repeat 11,01 for 4 windows → `pi_code` and `freq_int` are unchanged, `pi_valid` pulses 4 times, and `lock`=1 after the 4th window. One further all-01 window → `lock`=0 on that update.
- Gating and mid-window reset:
  - 4 qualified 11s, then 10 cycles of `en`=0 with `decision`=01, then 4 more qualified 11s → exactly one update, `pi_code`=4.
  - Separately: assert `rst` after 5 qualified decisions, then apply 8 qualified 01s → `pi_code`=123 and `freq_int`=−1.

Source files
------------

// File: rtl/cdr_loop_filter.sv
// CDR digital loop filter: decimates bang-bang phase-detector votes, then drives a
// proportional + integral path onto a wrapping phase-interpolator code and flags lock.
module cdr_loop_filter #(
    parameter int DEC     = 8,
    parameter int KP      = 4,
    parameter int KI      = 1,
    parameter int INT_W   = 12,
    parameter int FRAC    = 4,
    parameter int PI_W    = 7,
    parameter int LOCK_TH = 2,
    parameter int LOCK_N  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         decision,
    output logic [PI_W-1:0]    pi_code,
    output logic               pi_valid,
    output logic [INT_W-1:0]   freq_int,
    output logic               lock
);

    localparam int unsigned CNT_W = (DEC > 1) ? $clog2(DEC) : 1;
    localparam int unsigned SUM_W = $clog2(DEC + 1) + 1;
    localparam int unsigned LCK_W = $clog2(LOCK_N + 1);
    // Wide enough that gain terms, integrator and step never overflow before wrap/saturation.
    localparam int unsigned ACC_W = INT_W + PI_W + 34;

    localparam logic signed [ACC_W-1:0] FREQ_MAX = (ACC_W'(1) <<< (INT_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] FREQ_MIN = -(ACC_W'(1) <<< (INT_W - 1));

    logic        [CNT_W-1:0] win_cnt;
    logic signed [SUM_W-1:0] win_sum;
    logic        [LCK_W-1:0] lock_cnt;

    logic signed [SUM_W-1:0] vote;
    logic signed [SUM_W-1:0] tot;
    logic        [SUM_W-1:0] tot_abs;
    logic                    tot_pos;
    logic                    tot_neg;
    logic                    last;
    logic                    balanced;

    logic signed [ACC_W-1:0] ki_term;
    logic signed [ACC_W-1:0] kp_term;
    logic signed [ACC_W-1:0] freq_sum;
    logic signed [ACC_W-1:0] freq_new;
    logic signed [ACC_W-1:0] step;
    logic        [PI_W-1:0]  pi_next;
    logic        [LCK_W-1:0] lock_cnt_next;

    // Vote decode: early +1, late -1, anything else abstains.
    always_comb begin
        vote = '0;
        case (decision)
            2'b11:   vote = SUM_W'(1);
            2'b01:   vote = -SUM_W'(1);
            default: vote = '0;
        endcase
    end

    // Window total, sign, and the proportional/integral update for a completing window.
    always_comb begin
        last     = en && (win_cnt == CNT_W'(DEC - 1));
        tot      = win_sum + vote;
        tot_neg  = tot[SUM_W-1];
        tot_pos  = !tot_neg && (tot != '0);
        tot_abs  = tot_neg ? SUM_W'(-tot) : SUM_W'(tot);
        balanced = int'(tot_abs) <= LOCK_TH;

        ki_term = '0;
        kp_term = '0;
        if (tot_pos) begin
            ki_term = ACC_W'(KI);
            kp_term = ACC_W'(KP);
        end else if (tot_neg) begin
            ki_term = -ACC_W'(KI);
            kp_term = -ACC_W'(KP);
        end

        freq_sum = ACC_W'($signed(freq_int)) + ki_term;
        if (freq_sum > FREQ_MAX) begin
            freq_new = FREQ_MAX;
        end else if (freq_sum < FREQ_MIN) begin
            freq_new = FREQ_MIN;
        end else begin
            freq_new = freq_sum;
        end

        step    = kp_term + (freq_new >>> FRAC);
        pi_next = pi_code + PI_W'(step);
    end

    // Lock counter saturates at LOCK_N on balanced windows, clears on any unbalanced one.
    always_comb begin
        lock_cnt_next = '0;
        if (balanced) begin
            if (lock_cnt == LCK_W'(LOCK_N)) begin
                lock_cnt_next = lock_cnt;
            end else begin
                lock_cnt_next = lock_cnt + LCK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt  <= '0;
            win_sum  <= '0;
            lock_cnt <= '0;
            pi_code  <= '0;
            pi_valid <= 1'b0;
            freq_int <= '0;
            lock     <= 1'b0;
        end else begin
            pi_valid <= last;
            if (last) begin
                win_cnt  <= '0;
                win_sum  <= '0;
                freq_int <= INT_W'(freq_new);
                pi_code  <= pi_next;
                lock_cnt <= lock_cnt_next;
                lock     <= (lock_cnt_next == LCK_W'(LOCK_N));
            end else if (en) begin
                win_cnt <= win_cnt + CNT_W'(1);
                win_sum <= tot;
            end
        end
    end

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Self-checking bench for cdr_loop_filter: behavioural reference model feeding a
// scoreboard queue, plus fixed end-of-scenario expectations.
module tb_cdr_loop_filter;

    localparam int DEC     = 8;
    localparam int KP      = 4;
    localparam int KI      = 1;
    localparam int INT_W   = 12;
    localparam int FRAC    = 4;
    localparam int PI_W    = 7;
    localparam int LOCK_TH = 2;
    localparam int LOCK_N  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [1:0]        decision;
    logic [PI_W-1:0]   pi_code;
    logic              pi_valid;
    logic [INT_W-1:0]  freq_int;
    logic              lock;

    cdr_loop_filter #(
        .DEC(DEC), .KP(KP), .KI(KI), .INT_W(INT_W), .FRAC(FRAC),
        .PI_W(PI_W), .LOCK_TH(LOCK_TH), .LOCK_N(LOCK_N)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .decision(decision),
        .pi_code(pi_code), .pi_valid(pi_valid), .freq_int(freq_int), .lock(lock)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pi;
        int freq;
        int lck;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   pulses   = 0;

    int m_cnt, m_sum, m_freq, m_pi, m_lc;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int freq_s();
        return int'($signed(freq_int));
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_sum = 0; m_freq = 0; m_pi = 0; m_lc = 0;
        sb.delete();
    endtask

    // Reference behaviour for one qualified decision; pushes expectation on window end.
    task automatic model_step(input logic [1:0] d, output bit done);
        int vote, tot, s, step, mag;
        exp_t e;
        vote = (d == 2'b11) ? 1 : (d == 2'b01) ? -1 : 0;
        done = 1'b0;
        if (m_cnt == DEC - 1) begin
            tot = m_sum + vote;
            s   = (tot > 0) ? 1 : (tot < 0) ? -1 : 0;
            m_freq = m_freq + KI * s;
            if (m_freq > (1 << (INT_W - 1)) - 1) m_freq = (1 << (INT_W - 1)) - 1;
            if (m_freq < -(1 << (INT_W - 1)))    m_freq = -(1 << (INT_W - 1));
            step = KP * s + (m_freq >>> FRAC);
            m_pi = (m_pi + step) % (1 << PI_W);
            if (m_pi < 0) m_pi += (1 << PI_W);
            mag  = (tot < 0) ? -tot : tot;
            if (mag <= LOCK_TH) m_lc = (m_lc < LOCK_N) ? m_lc + 1 : LOCK_N;
            else                m_lc = 0;
            e.pi = m_pi; e.freq = m_freq; e.lck = (m_lc == LOCK_N) ? 1 : 0;
            sb.push_back(e);
            m_cnt = 0; m_sum = 0;
            done = 1'b1;
        end else begin
            m_cnt++;
            m_sum += vote;
        end
    endtask

    task automatic cycle(input bit e, input logic [1:0] d);
        bit   exp_v;
        exp_t x;
        en = e; decision = d;
        @(posedge clk);
        exp_v = 1'b0;
        if (e) model_step(d, exp_v);
        #1;
        check("pi_valid", int'(pi_valid), int'(exp_v));
        if (pi_valid) begin
            pulses++;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("sb_pi_code", int'(pi_code), x.pi);
                check("sb_freq_int", freq_s(), x.freq);
                check("sb_lock", int'(lock), x.lck);
            end
        end
    endtask

    task automatic run(input int n, input bit e, input logic [1:0] d);
        for (int i = 0; i < n; i++) cycle(e, d);
    endtask

    task automatic do_reset(input int n, input bit full_check);
        rst = 1'b1; en = 1'b1; decision = 2'b11;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("rst_pi_valid", int'(pi_valid), 0);
            if (full_check) begin
                check("rst_pi_code", int'(pi_code), 0);
                check("rst_freq_int", freq_s(), 0);
                check("rst_lock", int'(lock), 0);
            end
        end
        rst = 1'b0;
        model_reset();
        pulses = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; decision = 2'b00;
        model_reset();

        // Reset held with active stimulus
        do_reset(20, 1'b1);

        // One early window
        run(DEC, 1'b1, 2'b11);
        check("early1_pi_code", int'(pi_code), 4);
        check("early1_freq", freq_s(), 1);
        cycle(1'b0, 2'b11);
        check("early1_pulses", pulses, 1);

        // Late run, wraps below zero
        do_reset(2, 1'b0);
        run(16 * DEC, 1'b1, 2'b01);
        check("late_pi_code", int'(pi_code), 48);
        check("late_freq", freq_s(), -16);

        // Early run, wraps upward
        do_reset(2, 1'b0);
        run(31 * DEC, 1'b1, 2'b11);
        check("early_pi_code", int'(pi_code), 12);
        check("early_freq", freq_s(), 31);
        check("early_pulses", pulses, 31);

        // Balanced windows reach lock, one late window drops it
        do_reset(2, 1'b0);
        for (int i = 0; i < 4 * DEC / 2; i++) begin
            cycle(1'b1, 2'b11);
            cycle(1'b1, 2'b01);
        end
        check("bal_pulses", pulses, 4);
        check("bal_lock", int'(lock), 1);
        check("bal_pi_code", int'(pi_code), 0);
        check("bal_freq", freq_s(), 0);
        run(DEC, 1'b1, 2'b01);
        check("unlock_lock", int'(lock), 0);
        check("unlock_pi_code", int'(pi_code), 123);

        // Gated cycles are ignored
        do_reset(2, 1'b0);
        run(4, 1'b1, 2'b11);
        run(10, 1'b0, 2'b01);
        run(4, 1'b1, 2'b11);
        check("gate_pulses", pulses, 1);
        check("gate_pi_code", int'(pi_code), 4);

        // Reset mid-window discards the partial window
        do_reset(2, 1'b0);
        run(5, 1'b1, 2'b11);
        do_reset(1, 1'b0);
        run(DEC, 1'b1, 2'b01);
        check("midrst_pi_code", int'(pi_code), 123);
        check("midrst_freq", freq_s(), -1);
        check("midrst_pulses", pulses, 1);

        // Random decisions with random gating
        do_reset(2, 1'b0);
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
        end
        check("rand_pi_code", int'(pi_code), m_pi);
        check("rand_freq", freq_s(), m_freq);

        // Integrator saturation at both rails
        do_reset(2, 1'b0);
        run(2060 * DEC, 1'b1, 2'b11);
        check("satp_freq", freq_s(), 2047);
        check("satp_pi_code", int'(pi_code), m_pi);
        do_reset(2, 1'b0);
        run(2060 * DEC, 1'b1, 2'b01);
        check("satn_freq", freq_s(), -2048);
        check("satn_pi_code", int'(pi_code), m_pi);

        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
